sram_ctrl_param: RTL and testbench

Parametrised single-port, byte-enabled synchronous SRAM with a valid/ready request interface and an in-order response channel. It supersedes the fixed 128x32 array: width, depth and read latency are configurable. It adds an optional hardware clear sweep after reset, out-of-range address detection, and a write acknowledge. It sits between the core load/store unit or instruction fetch and on-chip storage.

---
 rtl/sram_ctrl_param_if.sv | 27 ++
 rtl/sram_ctrl_param.sv | 136 +++++++++++++
 tb/tb_sram_ctrl_param.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_param_if.sv
// Request/response bundle for sram_ctrl_param: a valid/ready request channel
// and a fixed-latency response channel with no backpressure.
interface sram_ctrl_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;
    logic                    init_done;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, init_done
    );
endinterface

// File: rtl/sram_ctrl_param.sv
// Parametrised single-port byte-enabled SRAM with optional post-reset clear
// sweep, out-of-range detection and an in-order fixed-latency response pipe.
module sram_ctrl_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 128,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              reset,
    sram_ctrl_param_if.slave bus
);
    // state | meaning
    // INIT  | clear sweep in progress (or being skipped); requests blocked
    // READY | accepting one request per cycle, no internal stalls

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ready_q;
    logic                  init_done_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  wr_en;
    logic                  clr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_data;

    assign accept   = bus.req_valid && ready_q;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign wr_en    = accept && bus.req_write && in_range;
    assign clr_en   = CLEAR_ON_RESET && (state == ST_INIT);
    assign rd_word  = in_range ? mem[bus.req_addr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            clr_cnt     <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!CLEAR_ON_RESET || clr_cnt == LAST_ADDR) begin
                        state       <= ST_READY;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    ready_q     <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Contents survive reset; only the sweep or accepted writes change them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (bus.req_be[b]) begin
                        mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // First response stage: data is captured only on acceptance so the
    // output holds its last value between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && !in_range;
            if (accept) begin
                s1_data <= bus.req_write ? '0 : rd_word;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  o_valid;
            logic                  o_err;
            logic [DATA_WIDTH-1:0] o_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    o_valid <= 1'b0;
                    o_err   <= 1'b0;
                    o_data  <= '0;
                end else begin
                    o_valid <= s1_valid;
                    o_err   <= s1_err;
                    if (s1_valid) begin
                        o_data <= s1_data;
                    end
                end
            end

            assign bus.resp_valid = o_valid;
            assign bus.resp_err   = o_err;
            assign bus.resp_rdata = o_data;
        end else begin : g_lat1
            assign bus.resp_valid = s1_valid;
            assign bus.resp_err   = s1_err;
            assign bus.resp_rdata = s1_data;
        end
    endgenerate

    assign bus.req_ready = ready_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_sram_ctrl_param.sv
// Drives three sram_ctrl_param configurations with one request stream and
// checks every output every cycle against an array/queue model of the memory.
module tb_sram_ctrl_param;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;

    always #5 clk = ~clk;

    sram_ctrl_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_a ();
    sram_ctrl_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_b ();
    sram_ctrl_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_c ();

    assign if_a.req_valid = req_valid;
    assign if_a.req_write = req_write;
    assign if_a.req_addr  = req_addr;
    assign if_a.req_be    = req_be;
    assign if_a.req_wdata = req_wdata;
    assign if_b.req_valid = req_valid;
    assign if_b.req_write = req_write;
    assign if_b.req_addr  = req_addr;
    assign if_b.req_be    = req_be;
    assign if_b.req_wdata = req_wdata;
    assign if_c.req_valid = req_valid;
    assign if_c.req_write = req_write;
    assign if_c.req_addr  = req_addr[3:0];
    assign if_c.req_be    = req_be;
    assign if_c.req_wdata = req_wdata;

    sram_ctrl_param #(.DATA_WIDTH(32), .DEPTH(128), .ADDR_WIDTH(7),
                      .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    sram_ctrl_param #(.DATA_WIDTH(32), .DEPTH(100), .ADDR_WIDTH(7),
                      .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    sram_ctrl_param #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4),
                      .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0))
        u_c (.clk(clk), .reset(reset), .bus(if_c));

    logic        act_v [NI];
    logic        act_e [NI];
    logic        act_r [NI];
    logic        act_d [NI];
    logic [31:0] act_rd[NI];

    assign act_v[0] = if_a.resp_valid;  assign act_v[1] = if_b.resp_valid;  assign act_v[2] = if_c.resp_valid;
    assign act_e[0] = if_a.resp_err;    assign act_e[1] = if_b.resp_err;    assign act_e[2] = if_c.resp_err;
    assign act_r[0] = if_a.req_ready;   assign act_r[1] = if_b.req_ready;   assign act_r[2] = if_c.req_ready;
    assign act_d[0] = if_a.init_done;   assign act_d[1] = if_b.init_done;   assign act_d[2] = if_c.init_done;
    assign act_rd[0] = if_a.resp_rdata; assign act_rd[1] = if_b.resp_rdata; assign act_rd[2] = if_c.resp_rdata;

    // Model: per-configuration word arrays, byte-known masks and a queue of
    // expected responses stamped with the cycle they must appear in.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          chk;
        bit          err;
    } exp_t;

    int          depth_of[NI] = '{128, 100, 16};
    int          lat_of  [NI] = '{1, 2, 1};
    bit          clr_of  [NI] = '{1'b1, 1'b1, 1'b0};
    exp_t        expq    [NI][$];
    logic [31:0] mdl_mem [NI][128];
    logic [3:0]  mdl_kn  [NI][128];
    logic [31:0] last_rd [NI];

    int cyc = 0;
    int rel = 0;
    bit rst_q = 1'b0;
    bit started = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
        if (reset) rel <= 0;
        else       rel <= rel + 1;
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%08h expected 0x%08h", name, id, cyc, act, exp);
        end
    endtask

    task automatic compare_one(input int i);
        bit exp_rdy;
        bit exp_v;
        if (rst_q) begin
            expq[i].delete();
            last_rd[i] = '0;
            for (int a = 0; a < 128; a++) begin
                mdl_mem[i][a] = '0;
                mdl_kn[i][a]  = clr_of[i] ? 4'hF : 4'h0;
            end
            chk("reset_ready", i, 32'(act_r[i]), 32'd0);
            chk("reset_done",  i, 32'(act_d[i]), 32'd0);
            chk("reset_valid", i, 32'(act_v[i]), 32'd0);
            chk("reset_err",   i, 32'(act_e[i]), 32'd0);
            chk("reset_rdata", i, act_rd[i], 32'd0);
        end else begin
            exp_rdy = clr_of[i] ? (rel >= depth_of[i]) : (rel >= 1);
            chk("req_ready", i, 32'(act_r[i]), 32'(exp_rdy));
            chk("init_done", i, 32'(act_d[i]), 32'(exp_rdy));
            exp_v = (expq[i].size() > 0) && (expq[i][0].due == cyc);
            chk("resp_valid", i, 32'(act_v[i]), 32'(exp_v));
            if (exp_v) begin
                if (expq[i][0].chk) begin
                    chk("resp_rdata", i, act_rd[i], expq[i][0].data);
                    last_rd[i] = expq[i][0].data;
                end else begin
                    last_rd[i] = act_rd[i];
                end
                chk("resp_err", i, 32'(act_e[i]), 32'(expq[i][0].err));
                void'(expq[i].pop_front());
            end else begin
                chk("rdata_hold", i, act_rd[i], last_rd[i]);
                chk("err_idle", i, 32'(act_e[i]), 32'd0);
            end
            while (expq[i].size() > 0 && expq[i][0].due <= cyc) void'(expq[i].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) started = 1'b1;
        if (started) begin
            for (int i = 0; i < NI; i++) compare_one(i);
        end
    end

    task automatic model_accept(input bit wr, input logic [6:0] a, input logic [3:0] be, input logic [31:0] wd);
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            int   idx;
            bit   oor;
            idx    = (i == 2) ? int'(a[3:0]) : int'(a);
            oor    = idx >= depth_of[i];
            e.due  = cyc + lat_of[i];
            e.err  = oor;
            e.chk  = 1'b1;
            e.data = '0;
            if (wr) begin
                if (!oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mdl_mem[i][idx][8*b +: 8] = wd[8*b +: 8];
                            mdl_kn[i][idx][b] = 1'b1;
                        end
                    end
                end
            end else if (!oor) begin
                e.data = mdl_mem[i][idx];
                e.chk  = (mdl_kn[i][idx] == 4'hF);
            end
            expq[i].push_back(e);
        end
    endtask

    task automatic drive(input bit v, input bit wr, input logic [6:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (reset || rel < 128) v = 1'b0;
        req_valid = v;
        req_write = wr;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        if (v) model_accept(wr, a, be, wd);
    endtask

    task automatic issue(input bit v, input bit wr, input logic [6:0] a, input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        drive(v, wr, a, be, wd);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 7'd0, 4'h0, 32'd0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (rel < 128 && guard < 400) begin
            idle();
            guard++;
        end
        if (rel < 128) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready: rel %0d required 128", rel);
        end
    endtask

    task automatic rand_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            bit          v;
            bit          wr;
            logic [6:0]  a;
            logic [3:0]  be;
            logic [31:0] wd;
            v  = ($urandom_range(0, 3) != 0);
            wr = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(96, 111)) : 7'($urandom_range(0, 127));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            issue(v, wr, a, be, wd);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear sweep timing: C skips it, B needs 100 cycles, A needs 128.
        @(posedge clk); #1;
        chk("c_ready_cycle1", 2, 32'(if_c.req_ready), 32'd1);
        chk("a_ready_cycle1", 0, 32'(if_a.req_ready), 32'd0);
        repeat (98) @(posedge clk);
        #1;
        chk("b_ready_cycle99", 1, 32'(if_b.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("b_ready_cycle100", 1, 32'(if_b.req_ready), 32'd1);
        repeat (27) @(posedge clk);
        #1;
        chk("a_ready_cycle127", 0, 32'(if_a.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("a_ready_cycle128", 0, 32'(if_a.req_ready), 32'd1);
        chk("a_done_cycle128", 0, 32'(if_a.init_done), 32'd1);

        drive(1'b1, 1'b0, 7'h7F, 4'h0, 32'd0);
        idle();
        @(negedge clk);
        chk("read_7f_valid", 0, 32'(if_a.resp_valid), 32'd1);
        chk("read_7f_data", 0, if_a.resp_rdata, 32'h0000_0000);

        issue(1'b1, 1'b1, 7'd5, 4'b1111, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 7'd5, 4'b0001, 32'h0000_00AA);
        @(negedge clk);
        chk("wr_resp_rdata", 0, if_a.resp_rdata, 32'd0);
        chk("wr_resp_err", 0, 32'(if_a.resp_err), 32'd0);
        issue(1'b1, 1'b0, 7'd5, 4'b0000, 32'd0);
        idle();
        @(negedge clk);
        chk("byte_merge", 0, if_a.resp_rdata, 32'hDEAD_BEAA);

        issue(1'b1, 1'b1, 7'd3, 4'b1111, 32'h1234_5678);
        issue(1'b1, 1'b0, 7'd3, 4'b0000, 32'd0);
        issue(1'b1, 1'b0, 7'd4, 4'b0000, 32'd0);
        @(negedge clk);
        chk("b2b_raw", 0, if_a.resp_rdata, 32'h1234_5678);
        issue(1'b1, 1'b0, 7'd3, 4'b0000, 32'd0);
        @(negedge clk);
        chk("b2b_addr4", 0, if_a.resp_rdata, 32'h0000_0000);
        idle();
        @(negedge clk);
        chk("b2b_valid", 0, 32'(if_a.resp_valid), 32'd1);
        chk("b2b_addr3", 0, if_a.resp_rdata, 32'h1234_5678);

        issue(1'b1, 1'b1, 7'd120, 4'b1111, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 7'd100, 4'b0000, 32'd0);
        @(negedge clk);
        chk("lat2_not_early", 1, 32'(if_b.resp_valid), 32'd0);
        issue(1'b1, 1'b0, 7'd20, 4'b0000, 32'd0);
        @(negedge clk);
        chk("oor_write_err", 1, 32'(if_b.resp_err), 32'd1);
        idle();
        @(negedge clk);
        chk("oor_read_err", 1, 32'(if_b.resp_err), 32'd1);
        chk("oor_read_data", 1, if_b.resp_rdata, 32'd0);
        idle();
        @(negedge clk);
        chk("no_alias_err", 1, 32'(if_b.resp_err), 32'd0);
        chk("no_alias_data", 1, if_b.resp_rdata, 32'd0);

        rand_traffic(300);

        // Reset one cycle after a latency-2 read is accepted.
        issue(1'b1, 1'b0, 7'd5, 4'b0000, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("lat2_pre_reset", 1, 32'(if_b.resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lat2_flushed", 1, 32'(if_b.resp_valid), 32'd0);
        wait_ready();
        rand_traffic(200);

        // Reset partway through the sweep restarts it from zero.
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (127) @(posedge clk);
        #1;
        chk("restart_ready_127", 0, 32'(if_a.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("restart_ready_128", 0, 32'(if_a.req_ready), 32'd1);
        rand_traffic(150);

        repeat (4) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
